approx_adder_err_accum: RTL and testbench
=========================================

Name: approx_adder_err_accum

Overview:
- Error-metric stage directly downstream of the 16-bit ripple-carry approximate adders (RC_* family).
- Per sample it consumes the operands and the approximate adder's (WIDTH+1)-bit output, and recomputes the exact sum internally.
- Over a run of 2^NSAMP_LOG2 samples it accumulates squared error, maximum absolute error and erroneous-sample count.
- Results feed the area/MSE characterisation flow; one result is emitted per run.

Parameters:
- WIDTH, 16, operand width; the approximate sum is WIDTH+1 bits.
- NSAMP_LOG2, 10, log2 of samples per run; N = 2^NSAMP_LOG2.
- ACC_W, 2*(WIDTH+1)+NSAMP_LOG2, squared-error accumulator width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accept.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_approx  in  WIDTH+1  approximate adder output for (in_a, in_b).
- res_valid  out  1  run result valid.
- res_ready  in  1  result consumed.
- res_sq_sum  out  ACC_W  sum of (approx-exact)^2 over the run.
- res_abs_max  out  WIDTH+1  max |approx-exact| over the run.
- res_err_cnt  out  NSAMP_LOG2+1  number of samples with approx != exact.
- busy  out  1  state != IDLE.

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- On rst, every register clears: state=IDLE, in_ready=0, res_valid=0, res_sq_sum=0, res_abs_max=0, res_err_cnt=0, busy=0, sample counter=0, pipeline valids=0.
- rst mid-run aborts the run; partial results are discarded and never presented.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, clear accumulators and sample counter, go to RUN.
  - RUN: in_ready=1 while accepted count < N. A sample is accepted when in_valid && in_ready. When the Nth sample is accepted, in_ready drops combinationally the same cycle and the state goes to DRAIN.
  - DRAIN: in_ready=0. Stay 2 cycles until both pipeline stages are empty, then go to DONE.
  - DONE: res_valid=1; outputs are stable while res_ready=0. On res_valid && res_ready, go to IDLE and drop res_valid the next cycle. Result registers keep their values until the next start.
- start is ignored in RUN, DRAIN and DONE. start coinciding with rst is ignored; reset wins.
- Pipeline, 2 stages:
  - S1 registers exact = in_a + in_b (WIDTH+1 bits, zero-extended) and in_approx.
  - S2 computes d = approx - exact as a signed WIDTH+2-bit value, |d| as WIDTH+1 bits, and d^2 as 2*(WIDTH+1) bits. It then updates sq_sum += d^2, abs_max = max(abs_max, |d|), and err_cnt += (d != 0).
- Latency: if the Nth sample is accepted at edge t, it is accumulated at edge t+1 and res_valid is high after edge t+2.
- Overflow: ACC_W holds N*(2^(WIDTH+1)-1)^2, so no saturation is needed. err_cnt reaches exactly N without wrap.
- in_valid gaps in RUN stall counting only; the pipeline advances every cycle with bubbles.
- Inputs presented while in_ready=0 are ignored.

Decomposition:
- Package approx_err_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - ACC_W derivation function;
  - signed error type width WIDTH+2.
- One sub-module, approx_err_sq: a combinational S2 datapath (d, |d|, d^2) from exact/approx. The top level holds the FSM, counter, pipeline registers and accumulators.

Test Plan:
- Exact run (NSAMP_LOG2=2, N=4): approx = a+b for (1,2), (100,200), (65535,65535), (0,0) -> res_sq_sum=0, res_abs_max=0, res_err_cnt=0, res_valid after edge t+2.
- Positive error: 4 samples, approx = exact+3 -> res_sq_sum=36, res_abs_max=3, res_err_cnt=4.
- Mixed sign: errors {-5, 0, +2, 0} (e.g. a=10, b=10, approx=15) -> res_sq_sum=29, res_abs_max=5, res_err_cnt=2.
- Handshake:
  - in_valid toggling 1,0,1,0,... -> exactly 4 accepts.
  - in_ready=0 after the 4th accept.
  - res_ready held low 10 cycles -> res_valid and results stable.
  - Return to IDLE one cycle after res_ready.
- Control edges:
  - start pulsed during RUN -> counter and accumulators unchanged.
  - rst asserted after 2 accepts -> all outputs 0, state IDLE; a new start then yields results from fresh samples only.

Source files
------------

// File: rtl/approx_err_pkg.sv
// Shared types and width helpers for the approximate-adder
// error accumulator (run-level MSE / max-error / error-count stage).
package approx_err_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 16;

   // Signed difference approx - exact for the default operand width
   typedef logic signed [DEF_WIDTH+1:0] err_t;

   function automatic int err_w(input int width);
      return width + 2;
   endfunction

   // Sized so that N * (2^(WIDTH+1)-1)^2 can never overflow
   function automatic int acc_w(input int width, input int nsamp_log2);
      return 2 * (width + 1) + nsamp_log2;
   endfunction

endpackage

// File: rtl/approx_err_sq.sv
// Second-stage error datapath: signed difference, magnitude and
// square of (approx - exact).
module approx_err_sq
   import approx_err_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int EW    = err_w(WIDTH),
   localparam int SW    = 2 * (WIDTH + 1)
)(
   input  logic        [WIDTH:0] i_exact,
   input  logic        [WIDTH:0] i_approx,
   output logic signed [EW-1:0]  o_d,
   output logic        [WIDTH:0] o_abs,
   output logic        [SW-1:0]  o_sq
);

   logic [SW-1:0] w_abs_ext;

   always_comb begin
      o_d       = $signed({1'b0, i_approx}) - $signed({1'b0, i_exact});
      o_abs     = (i_approx >= i_exact) ? (i_approx - i_exact)
                                        : (i_exact - i_approx);
      w_abs_ext = {{(WIDTH+1){1'b0}}, o_abs};
      o_sq      = w_abs_ext * w_abs_ext;
   end

endmodule

// File: rtl/approx_adder_err_accum.sv
// Run-level error metrics for a ripple-carry approximate adder:
// squared-error sum, max |error| and erroneous-sample count.
module approx_adder_err_accum
   import approx_err_pkg::*;
#(
   parameter  int WIDTH      = 16,
   parameter  int NSAMP_LOG2 = 10,
   localparam int ACC_W      = acc_w(WIDTH, NSAMP_LOG2)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_a,
   input  logic [WIDTH-1:0]      in_b,
   input  logic [WIDTH:0]        in_approx,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ACC_W-1:0]      res_sq_sum,
   output logic [WIDTH:0]        res_abs_max,
   output logic [NSAMP_LOG2:0]   res_err_cnt,
   output logic                  busy
);

   localparam int CNT_W = NSAMP_LOG2 + 1;
   localparam int SQ_W  = 2 * (WIDTH + 1);
   localparam int EW    = err_w(WIDTH);

   localparam logic [CNT_W-1:0] N_SAMP = CNT_W'(1) << NSAMP_LOG2;
   localparam logic [CNT_W-1:0] N_LAST = N_SAMP - CNT_W'(1);

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_s1_vld;
   logic [WIDTH:0]      r_s1_exact;
   logic [WIDTH:0]      r_s1_approx;
   logic [ACC_W-1:0]    r_sq_sum;
   logic [WIDTH:0]      r_abs_max;
   logic [CNT_W-1:0]    r_err_cnt;

   state_t              w_state_nxt;
   logic                w_start;
   logic                w_accept;
   logic                w_last;
   logic [WIDTH:0]      w_exact;
   logic signed [EW-1:0] w_d;
   logic [WIDTH:0]      w_abs;
   logic [SQ_W-1:0]     w_sq;
   logic                w_nz;

   assign w_start  = (r_state == IDLE) && start;
   assign in_ready = (r_state == RUN) && (r_cnt < N_SAMP);
   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_cnt == N_LAST);
   assign w_exact  = {1'b0, in_a} + {1'b0, in_b};
   assign w_nz     = (w_d != '0);

   assign res_valid   = (r_state == DONE);
   assign busy        = (r_state != IDLE);
   assign res_sq_sum  = r_sq_sum;
   assign res_abs_max = r_abs_max;
   assign res_err_cnt = r_err_cnt;

   approx_err_sq #(
      .WIDTH (WIDTH)
   ) u_err_sq (
      .i_exact  (r_s1_exact),
      .i_approx (r_s1_approx),
      .o_d      (w_d),
      .o_abs    (w_abs),
      .o_sq     (w_sq)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:  if (w_start)             w_state_nxt = RUN;
         RUN:   if (w_accept && w_last)  w_state_nxt = DRAIN;
         // S1 empty means the last sample has reached the accumulators
         DRAIN: if (!r_s1_vld)           w_state_nxt = DONE;
         DONE:  if (res_ready)           w_state_nxt = IDLE;
         default:                        w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start)
            r_cnt <= '0;
         else if (w_accept)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld    <= 1'b0;
         r_s1_exact  <= '0;
         r_s1_approx <= '0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_exact  <= w_exact;
            r_s1_approx <= in_approx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sq_sum  <= '0;
         r_abs_max <= '0;
         r_err_cnt <= '0;
      end else if (w_start) begin
         r_sq_sum  <= '0;
         r_abs_max <= '0;
         r_err_cnt <= '0;
      end else if (r_s1_vld) begin
         r_sq_sum  <= r_sq_sum + {{NSAMP_LOG2{1'b0}}, w_sq};
         if (w_abs > r_abs_max)
            r_abs_max <= w_abs;
         r_err_cnt <= r_err_cnt + {{NSAMP_LOG2{1'b0}}, w_nz};
      end
   end

endmodule

// File: tb/tb_approx_adder_err_accum.sv
// Self-checking bench for approx_adder_err_accum with 4-sample runs:
// directed vector table, handshake/control sequences and random runs.
module tb_approx_adder_err_accum;

   localparam int W     = 16;
   localparam int NL    = 2;
   localparam int N     = 4;
   localparam int ACC_W = 2 * (W + 1) + NL;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_a = '0;
   logic [W-1:0]     in_b = '0;
   logic [W:0]       in_approx = '0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [ACC_W-1:0] res_sq_sum;
   logic [W:0]       res_abs_max;
   logic [NL:0]      res_err_cnt;
   logic             busy;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [N-1:0][W-1:0] a;
      logic [N-1:0][W-1:0] b;
      logic [N-1:0][W:0]   x;
      longint              sq;
      int                  amax;
      int                  cnt;
   } vec_t;

   vec_t tbl [3];
   vec_t rv;

   approx_adder_err_accum #(
      .WIDTH      (W),
      .NSAMP_LOG2 (NL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_approx   (in_approx),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_sq_sum  (res_sq_sum),
      .res_abs_max (res_abs_max),
      .res_err_cnt (res_err_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t ref_model(input vec_t v);
      vec_t   r;
      longint e;
      longint ad;
      r = v;
      r.sq = 0;
      r.amax = 0;
      r.cnt = 0;
      for (int i = 0; i < N; i++) begin
         e  = longint'(v.x[i]) - longint'(v.a[i]) - longint'(v.b[i]);
         ad = (e < 0) ? -e : e;
         r.sq += e * e;
         if (ad > longint'(r.amax)) r.amax = int'(ad);
         if (e != 0) r.cnt++;
      end
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      int   ex;
      for (int i = 0; i < N; i++) begin
         v.a[i] = W'($urandom);
         v.b[i] = W'($urandom);
         ex = int'(v.a[i]) + int'(v.b[i]);
         case ($urandom_range(0, 2))
            0:       v.x[i] = (W+1)'(ex);
            1:       v.x[i] = (W+1)'(ex + int'($urandom_range(0, 16)) - 8);
            default: v.x[i] = (W+1)'($urandom);
         endcase
      end
      v.sq = 0;
      v.amax = 0;
      v.cnt = 0;
      return v;
   endfunction

   task automatic check_res(input string tag, input vec_t v);
      check($sformatf("%s sq_sum", tag), res_sq_sum, v.sq);
      check($sformatf("%s abs_max", tag), res_abs_max, v.amax);
      check($sformatf("%s err_cnt", tag), res_err_cnt, v.cnt);
   endtask

   task automatic run_vec(input vec_t v, input string tag,
                          input bit toggle, input bit mid_start,
                          input int hold);
      int k;
      int cyc;
      bit acc;
      bit mid_done;
      k = 0;
      cyc = 0;
      mid_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (k < N && cyc < 200) begin
         in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
         start = 1'b0;
         if (mid_start && k == 2 && !mid_done) begin
            start = 1'b1;
            in_valid = 1'b0;
            mid_done = 1'b1;
         end
         if (in_valid) begin
            in_a = v.a[k];
            in_b = v.b[k];
            in_approx = v.x[k];
         end else begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_approx = (W+1)'($urandom);
         end
         acc = in_valid && in_ready;
         @(negedge clk);
         if (acc) k++;
         cyc++;
      end
      start = 1'b0;
      check($sformatf("%s accepts", tag), k, N);
      if (toggle) check($sformatf("%s cycles", tag), cyc, 2 * N - 1);
      // garbage offered while not ready must be dropped
      in_valid = 1'b1;
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_approx = (W+1)'($urandom);
      check($sformatf("%s ready_after_last", tag), in_ready, 0);
      check($sformatf("%s valid_t0", tag), res_valid, 0);
      @(negedge clk);
      check($sformatf("%s valid_t1", tag), res_valid, 0);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("%s valid_t2", tag), res_valid, 1);
      check_res(tag, v);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check($sformatf("%s hold_valid", tag), res_valid, 1);
         check_res($sformatf("%s hold", tag), v);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check($sformatf("%s idle_valid", tag), res_valid, 0);
      check($sformatf("%s idle_busy", tag), busy, 0);
      check($sformatf("%s kept_sq", tag), res_sq_sum, v.sq);
   endtask

   initial begin
      // packed sample order: rightmost literal is sample 0
      tbl[0].a = {16'd0, 16'd65535, 16'd100, 16'd1};
      tbl[0].b = {16'd0, 16'd65535, 16'd200, 16'd2};
      tbl[0].x = {17'd0, 17'd131070, 17'd300, 17'd3};
      tbl[0].sq = 0;  tbl[0].amax = 0; tbl[0].cnt = 0;
      tbl[1].a = {16'd7, 16'd40000, 16'd1000, 16'd5};
      tbl[1].b = {16'd9, 16'd20000, 16'd2000, 16'd6};
      tbl[1].x = {17'd19, 17'd60003, 17'd3003, 17'd14};
      tbl[1].sq = 36; tbl[1].amax = 3; tbl[1].cnt = 4;
      tbl[2].a = {16'd0, 16'd3, 16'd1, 16'd10};
      tbl[2].b = {16'd0, 16'd4, 16'd1, 16'd10};
      tbl[2].x = {17'd0, 17'd9, 17'd2, 17'd15};
      tbl[2].sq = 29; tbl[2].amax = 5; tbl[2].cnt = 2;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst in_ready", in_ready, 0);
      check("rst res_valid", res_valid, 0);
      check("rst sq_sum", res_sq_sum, 0);
      check("rst abs_max", res_abs_max, 0);
      check("rst err_cnt", res_err_cnt, 0);
      rst = 1'b0;

      for (int i = 0; i < 3; i++)
         run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0, 1'b0,
                 (i == 0) ? 10 : 0);

      run_vec(tbl[2], "toggle", 1'b1, 1'b0, 0);
      run_vec(tbl[1], "midstart", 1'b0, 1'b1, 0);

      // abort after two accepts with large errors, reset coincides with start
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_a = 16'd100;
      in_b = 16'd100;
      in_approx = 17'd0;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("abort pre busy", busy, 1);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      check("abort busy", busy, 0);
      check("abort in_ready", in_ready, 0);
      check("abort res_valid", res_valid, 0);
      check("abort sq_sum", res_sq_sum, 0);
      check("abort abs_max", res_abs_max, 0);
      check("abort err_cnt", res_err_cnt, 0);
      @(negedge clk);
      check("abort still idle", busy, 0);
      run_vec(tbl[2], "after_rst", 1'b0, 1'b0, 0);

      for (int r = 0; r < 20; r++) begin
         rv = ref_model(rand_vec());
         run_vec(rv, $sformatf("rand%0d", r), r[0], 1'b0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
